register_scoreboard: RTL and testbench
======================================

REGISTER_SCOREBOARD -- requirements
Module: register_scoreboard

Interface
REQ-001 The block SHALL have one parameter: ISSUE_DEPTH, default 4, the pipeline distance from issue to writeback; legal range 2..7.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port issue_valid, input, 1 bit: an instruction leaves ID this cycle and writes a register.
REQ-005 The block SHALL have port issue_rd, input, 3 bits: the destination register of the issuing instruction.
REQ-006 The block SHALL have port stall, input, 1 bit: the IF/ID stages are frozen this cycle.
REQ-007 The block SHALL have port flush, input, 1 bit: kill the instructions younger than EX.
REQ-008 The block SHALL have port register_invalid, output, 8 x 3 bits: the per-register count of stages remaining until writeback; 0 = architectural value valid.
REQ-009 The block SHALL have port any_pending, output, 1 bit: OR of (register_invalid[i] != 0) over all i.
REQ-010 The block SHALL have port stall_count, output, 16 bits; this port is present only under the macro in the Configuration section.

Function
REQ-011 register_invalid SHALL be driven directly from registers, with no combinational path from any input.
REQ-012 Aging: each cycle, every nonzero entry SHALL decrement by 1, with the stall and flush exceptions below.
REQ-013 Stall: with stall=1, entries equal to ISSUE_DEPTH (producer still in ID) SHALL hold; all other nonzero entries SHALL still decrement, because EX and later stages keep advancing.
REQ-014 Issue: with issue_valid=1 and stall=0 and flush=0, entry issue_rd SHALL load ISSUE_DEPTH-1 next cycle, overriding any aging or older pending value; the newest writer wins.
REQ-015 issue_valid SHALL be ignored while stall=1 or flush=1.
REQ-016 Flush: with flush=1, entries with value >= ISSUE_DEPTH-1 SHALL clear to 0; entries below that value SHALL decrement normally.
REQ-017 flush SHALL take priority over stall.
REQ-018 An entry at 1 SHALL reach 0 next cycle; entries SHALL never wrap below 0.
REQ-019 Issue to register 0 SHALL be tracked identically to any other register; there is no special case.
REQ-020 Simultaneous issue to a register and that register's entry reaching 0 SHALL result in ISSUE_DEPTH-1.
REQ-021 any_pending SHALL be combinational from the registered entries.

Reset
REQ-022 With reset=1 at a clock edge, all register_invalid entries SHALL be 0 next cycle, regardless of issue, stall or flush.
REQ-023 After reset, any_pending SHALL be 0 and stall_count (when present) SHALL be 0.
REQ-024 Reset asserted mid-operation SHALL discard all pending entries with no draining.

Configuration
REQ-025 Macro SCOREBOARD_STALL_COUNT_EN, when defined, SHALL add port stall_count: a counter that increments by 1 on each cycle with stall=1 and reset=0, saturates at 16'hFFFF, and clears only on reset.
REQ-026 Without SCOREBOARD_STALL_COUNT_EN, the stall_count port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-027 Reset, then issue rd=5 for one cycle (ISSUE_DEPTH=4) -> register_invalid[5] reads 3, 2, 1, 0 on the following cycles; any_pending falls with the 0.
REQ-028 Issue rd=2; next cycle stall=1 for 2 cycles -> entry 2 goes 3, 2, 1, unaffected by stall; a second issue_valid during the stall is ignored.
REQ-029 Issue rd=3, then rd=3 again 2 cycles later -> entry reads 3, 2, then 3, 2, 1, 0.
REQ-030 Entries 1 and 4 at values 3 and 1, flush=1 -> entry 1 becomes 0 and entry 4 becomes 0; an issue_valid held in the same cycle has no effect.
REQ-031 reset=1 while entries 0..7 are all nonzero, with issue_valid=1 -> all entries read 0 next cycle.
REQ-032 With SCOREBOARD_STALL_COUNT_EN defined, 70000 stall cycles -> stall_count saturates at 65535; after reset it reads 0.

Source files
------------

// File: rtl/register_scoreboard.sv
// Register scoreboard: per-register countdown of pipeline stages until writeback.
// Optional stall cycle counter enabled by defining SCOREBOARD_STALL_COUNT_EN.
module register_scoreboard #(
   parameter int ISSUE_DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             issue_valid,
   input  logic [2:0]       issue_rd,
   input  logic             stall,
   input  logic             flush,
   output logic [7:0][2:0]  register_invalid,
   output logic             any_pending
`ifdef SCOREBOARD_STALL_COUNT_EN
   ,
   output logic [15:0]      stall_count
`endif
);

   localparam logic [2:0] LP_DEPTH = 3'(ISSUE_DEPTH);
   localparam logic [2:0] LP_LOAD  = 3'(ISSUE_DEPTH - 1);

   logic [7:0][2:0] r_inv;
   logic [7:0][2:0] w_inv_next;
   logic            w_issue_en;

   assign w_issue_en = issue_valid & ~stall & ~flush;

   // Flush outranks stall; a fresh issue overrides whatever aging produced.
   always_comb begin
      w_inv_next = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (flush) begin
            if (r_inv[i] >= LP_LOAD)
               w_inv_next[i] = '0;
            else if (r_inv[i] != '0)
               w_inv_next[i] = r_inv[i] - 3'd1;
         end else if (stall) begin
            if (r_inv[i] == LP_DEPTH)
               w_inv_next[i] = r_inv[i];
            else if (r_inv[i] != '0)
               w_inv_next[i] = r_inv[i] - 3'd1;
         end else begin
            if (r_inv[i] != '0)
               w_inv_next[i] = r_inv[i] - 3'd1;
            if (w_issue_en && (issue_rd == 3'(i)))
               w_inv_next[i] = LP_LOAD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_inv <= '0;
      else
         r_inv <= w_inv_next;
   end

   assign register_invalid = r_inv;
   assign any_pending      = |r_inv;

`ifdef SCOREBOARD_STALL_COUNT_EN
   logic [15:0] r_stall_count;

   always_ff @(posedge clk) begin
      if (reset)
         r_stall_count <= '0;
      else if (stall && (r_stall_count != '1))
         r_stall_count <= r_stall_count + 16'd1;
   end

   assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Bench for register_scoreboard: directed scenarios plus random traffic
// compared against a per-register countdown model.
module tb_register_scoreboard;

   localparam int D = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            issue_valid = 1'b0;
   logic [2:0]      issue_rd = '0;
   logic            stall = 1'b0;
   logic            flush = 1'b0;
   logic [7:0][2:0] register_invalid;
   logic            any_pending;
`ifdef SCOREBOARD_STALL_COUNT_EN
   logic [15:0]     stall_count;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int model [8];
   int model_sc = 0;

   register_scoreboard #(.ISSUE_DEPTH(D)) u_dut (
      .clk              (clk),
      .reset            (reset),
      .issue_valid      (issue_valid),
      .issue_rd         (issue_rd),
      .stall            (stall),
      .flush            (flush),
      .register_invalid (register_invalid),
      .any_pending      (any_pending)
`ifdef SCOREBOARD_STALL_COUNT_EN
      ,
      .stall_count      (stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Behavioural model: each entry counts stages left; one cycle of pipeline motion.
   function automatic void model_cycle(input bit r, input bit iv, input int rd,
                                       input bit st, input bit fl);
      int nxt [8];
      for (int i = 0; i < 8; i++) begin
         int v = model[i];
         if (r)                    nxt[i] = 0;
         else if (fl && v >= D-1)  nxt[i] = 0;
         else if (!fl && st && v == D) nxt[i] = v;
         else                      nxt[i] = (v > 0) ? v - 1 : 0;
      end
      if (!r && iv && !st && !fl) nxt[rd] = D - 1;
      model = nxt;
      if (r) model_sc = 0;
      else if (st && model_sc < 65535) model_sc++;
   endfunction

   task automatic compare_all();
      bit pend = 0;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("entry%0d", i), int'(register_invalid[i]), model[i]);
         if (model[i] != 0) pend = 1;
      end
      check("any_pending", int'(any_pending), int'(pend));
`ifdef SCOREBOARD_STALL_COUNT_EN
      check("stall_count", int'(stall_count), model_sc);
`endif
   endtask

   task automatic step(input bit r, input bit iv, input int rd, input bit st, input bit fl);
      reset = r; issue_valid = iv; issue_rd = 3'(rd); stall = st; flush = fl;
      @(posedge clk);
      model_cycle(r, iv, rd, st, fl);
      #1;
      compare_all();
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset state
      step(1, 1, 3, 1, 1);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) check("reset_entry", int'(register_invalid[i]), 0);
      check("reset_pending", int'(any_pending), 0);

      // Single issue countdown on r5
      step(0, 1, 5, 0, 0);
      check("r5_t1", int'(register_invalid[5]), 3);
      idle(); check("r5_t2", int'(register_invalid[5]), 2);
      idle(); check("r5_t3", int'(register_invalid[5]), 1);
      check("r5_pend_hi", int'(any_pending), 1);
      idle(); check("r5_t4", int'(register_invalid[5]), 0);
      check("r5_pend_lo", int'(any_pending), 0);

      // Stall does not hold a producer already past ID; issue during stall ignored
      step(0, 1, 2, 0, 0); check("st_t1", int'(register_invalid[2]), 3);
      step(0, 1, 6, 1, 0); check("st_t2", int'(register_invalid[2]), 2);
      step(0, 1, 6, 1, 0); check("st_t3", int'(register_invalid[2]), 1);
      check("st_ignored", int'(register_invalid[6]), 0);
      idle(); idle();

      // Re-issue of the same register restarts the count
      step(0, 1, 3, 0, 0); check("re_t1", int'(register_invalid[3]), 3);
      idle();              check("re_t2", int'(register_invalid[3]), 2);
      step(0, 1, 3, 0, 0); check("re_t3", int'(register_invalid[3]), 3);
      idle();              check("re_t4", int'(register_invalid[3]), 2);
      idle();              check("re_t5", int'(register_invalid[3]), 1);
      idle();              check("re_t6", int'(register_invalid[3]), 0);

      // Flush: young entry cleared, old entry drains, held issue ignored
      step(0, 1, 4, 0, 0); idle();
      step(0, 1, 1, 0, 0);
      check("fl_pre1", int'(register_invalid[1]), 3);
      check("fl_pre4", int'(register_invalid[4]), 1);
      step(0, 1, 7, 1, 1);
      check("fl_e1", int'(register_invalid[1]), 0);
      check("fl_e4", int'(register_invalid[4]), 0);
      check("fl_e7", int'(register_invalid[7]), 0);

      // Issue coinciding with entry reaching zero; register 0 tracked normally
      step(0, 1, 0, 0, 0); idle(); idle();
      step(0, 1, 0, 0, 0); check("zero_reissue", int'(register_invalid[0]), 3);

      // Reset mid-operation with issue held
      step(0, 1, 6, 0, 0); step(0, 1, 7, 0, 0);
      step(1, 1, 5, 0, 0);
      for (int i = 0; i < 8; i++) check("midreset", int'(register_invalid[i]), 0);

      // Random traffic
      for (int n = 0; n < 400; n++) begin
         bit r  = ($urandom_range(0, 39) == 0);
         bit iv = ($urandom_range(0, 3) != 0);
         bit st = ($urandom_range(0, 4) == 0);
         bit fl = ($urandom_range(0, 9) == 0);
         step(r, iv, int'($urandom_range(0, 7)), st, fl);
      end

`ifdef SCOREBOARD_STALL_COUNT_EN
      step(1, 0, 0, 0, 0);
      for (int n = 0; n < 70000; n++) step(0, 0, 0, 1, 0);
      check("sc_sat", int'(stall_count), 65535);
      step(1, 0, 0, 1, 0);
      check("sc_reset", int'(stall_count), 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
